// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: steps the select through 00..11, settles, samples and packs the word.
// Optional free-running mode: define MUX_SCAN_CONTINUOUS_EN.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       o,
    output logic [1:0] s,
    output logic       busy,
    output logic       done,
    output logic [3:0] data
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state, state_n;
    logic [1:0] s_n;
    logic [3:0] cnt, cnt_n;
    logic [3:0] shadow, shadow_n;
    logic [3:0] data_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            s      <= '0;
            cnt    <= '0;
            shadow <= '0;
            data   <= '0;
        end else begin
            state  <= state_n;
            s      <= s_n;
            cnt    <= cnt_n;
            shadow <= shadow_n;
            data   <= data_n;
        end
    end

    always_comb begin
        state_n  = state;
        s_n      = s;
        cnt_n    = cnt;
        shadow_n = shadow;
        data_n   = data;
        busy     = (state != IDLE);
        done     = (state == DONE);
        case (state)
            IDLE: begin
                s_n = '0;
                if (start) begin
                    state_n = SETTLE;
                    cnt_n   = '0;
                end
            end
            SETTLE: begin
                cnt_n = cnt + 4'd1;
                if (cnt == CNT_LAST)
                    state_n = SAMPLE;
            end
            SAMPLE: begin
                shadow_n[s] = o;
                if (s == 2'b11) begin
                    // Last channel is folded in directly so data sees this edge's sample.
                    data_n  = {o, shadow[2:0]};
                    state_n = DONE;
                end else begin
                    s_n     = s + 2'd1;
                    cnt_n   = '0;
                    state_n = SETTLE;
                end
            end
            DONE: begin
                s_n = '0;
`ifdef MUX_SCAN_CONTINUOUS_EN
                cnt_n   = '0;
                state_n = SETTLE;
`else
                state_n = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl with a behavioural 4:1 mux closing the loop.
module tb_mux_scan_ctrl;

`ifdef MUX_SCAN_CONTINUOUS_EN
    localparam int S = 1;
`else
    localparam int S = 2;
`endif
    localparam int P        = S + 1;
    localparam int DONE_OFS = 1 + 4 * P;

    typedef struct {
        logic [3:0] data;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [3:0] i;
        logic [3:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       o;
    logic [1:0] s;
    logic       busy;
    logic       done;
    logic [3:0] data;
    logic [3:0] mux_i = 4'b0000;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_count = 0;
    logic prev_done = 1'b0;
    exp_t sbq[$];
    vec_t vecs[6];

    mux_scan_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .o    (o),
        .s    (s),
        .busy (busy),
        .done (done),
        .data (data)
    );

    assign o = mux_i[s];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < bound);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done in %0d cycles, required a pulse", bound);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest expected scan.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            done_count++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pulse", cyc);
            end else begin
                e = sbq.pop_front();
                chk("scan_data", 32'(data), 32'(e.data));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
            chk("done_one_cycle", 32'(prev_done), 0);
        end
        prev_done = done & ~rst;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        vecs[0] = '{i: 4'b0000, exp: 4'b0000};
        vecs[1] = '{i: 4'b1111, exp: 4'b1111};
        vecs[2] = '{i: 4'b0001, exp: 4'b0001};
        vecs[3] = '{i: 4'b1000, exp: 4'b1000};
        vecs[4] = '{i: 4'b0100, exp: 4'b0100};
        vecs[5] = '{i: 4'b1011, exp: 4'b1011};

        // asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_s", 32'(s), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_data", 32'(data), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

`ifdef MUX_SCAN_CONTINUOUS_EN
        mux_i = 4'b0011;
        start = 1'b1;
        c = cyc;
        for (int n = 0; n < 4; n++)
            sbq.push_back('{4'b0011, c + DONE_OFS + n * (4 * P + 1)});
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 4 * P + 3 * (4 * P + 1) + 2; k++) begin
            @(negedge clk);
            start = (k == 5 || k == 4 * P + 2) ? 1'b1 : 1'b0;
            chk("cont_busy", 32'(busy), 1);
        end
        start = 1'b0;
        chk("cont_done_count", 32'(done_count), 4);
        #2 rst = 1'b1;
        #1;
        chk("cont_rst_busy", 32'(busy), 0);
        chk("cont_rst_s", 32'(s), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("cont_stays_idle", 32'(busy), 0);
`else
        // basic scan, cycle-by-cycle select trace
        mux_i = 4'b1010;
        start = 1'b1;
        c = cyc;
        sbq.push_back('{4'b1010, c + DONE_OFS});
        for (int k = 0; k <= 4 * P; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk("scan_s", 32'(s), (k < 4 * P) ? 32'(k / P) : 32'(3));
            chk("scan_busy", 32'(busy), 1);
            chk("scan_done", 32'(done), 32'(k == 4 * P));
        end
        @(negedge clk);
        chk("end_busy", 32'(busy), 0);
        chk("end_s", 32'(s), 0);
        chk("end_done", 32'(done), 0);
        chk("end_data", 32'(data), 32'(4'b1010));

        // table of input patterns
        foreach (vecs[v]) begin
            @(negedge clk);
            mux_i = vecs[v].i;
            start = 1'b1;
            sbq.push_back('{vecs[v].exp, cyc + DONE_OFS});
            @(negedge clk);
            start = 1'b0;
            wait_done(8 * P + 10);
            @(negedge clk);
            chk("vec_data_hold", 32'(data), 32'(vecs[v].exp));
            chk("vec_idle", 32'(busy), 0);
        end

        // back-to-back with start held; input changes during first DONE
        @(negedge clk);
        mux_i = 4'b1010;
        start = 1'b1;
        c = cyc;
        sbq.push_back('{4'b1010, c + DONE_OFS});
        sbq.push_back('{4'b0110, c + DONE_OFS + 4 * P + 2});
        wait_done(8 * P + 10);
        mux_i = 4'b0110;
        for (int n = 0; n < 8 * P; n++) begin
            @(negedge clk);
            if (done) break;
            chk("b2b_data_held", 32'(data), 32'(4'b1010));
        end
        chk("b2b_second_done", 32'(done), 1);
        start = 1'b0;
        @(negedge clk);
        chk("b2b_busy_fall", 32'(busy), 0);
        chk("b2b_done_fall", 32'(done), 0);

        // start pulses while busy are dropped
        @(negedge clk);
        mux_i = 4'b1001;
        start = 1'b1;
        c = done_count;
        sbq.push_back('{4'b1001, cyc + DONE_OFS});
        for (int k = 0; k <= 4 * P + 6; k++) begin
            @(negedge clk);
            start = (k == 3 || k == 8 || k == 4 * P) ? 1'b1 : 1'b0;
        end
        chk("ignored_start_done_count", 32'(done_count - c), 1);
        chk("ignored_start_idle", 32'(busy), 0);

        // abort after the channel 2 sample
        @(negedge clk);
        mux_i = 4'b0101;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3 * P) @(negedge clk);
        chk("abort_pre_s", 32'(s), 3);
        #2 rst = 1'b1;
        #1;
        chk("abort_s", 32'(s), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_data", 32'(data), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3 * P) begin
            @(negedge clk);
            chk("abort_data_held", 32'(data), 0);
        end
        mux_i = 4'b1100;
        start = 1'b1;
        sbq.push_back('{4'b1100, cyc + DONE_OFS});
        @(negedge clk);
        start = 1'b0;
        wait_done(8 * P + 10);
        @(negedge clk);
        chk("fresh_data", 32'(data), 32'(4'b1100));
`endif

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
